add_sub_pipe: RTL and testbench
===============================

ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; even, >= 8.
REQ-002 SHALL have parameter LO_W, default WIDTH/2: bits computed in stage 1; 1 <= LO_W < WIDTH.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  stage 1 can accept this cycle.
REQ-007 A, B  input  WIDTH each  operands.
REQ-008 Sub  input  1  1: A-B; 0: A+B.
REQ-009 Sign  input  1  1: two's-complement overflow/compare rules; 0: unsigned.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts this cycle.
REQ-012 S  output  WIDTH  result.
REQ-013 Z, V, N, C  output  1 each  zero, overflow, less-than/negative, raw carry-out.

Function
REQ-014 SHALL be a 2-stage pipeline: a beat is accepted on in_valid&in_ready and appears on out_valid exactly 2 cycles later with no stall.
REQ-015 Stage 1 SHALL compute S[LO_W-1:0] and its carry from A + (Sub ? ~B : B) + Sub, registering the upper operand bits, Sub, Sign, and the carry.
REQ-016 Stage 2 SHALL complete the upper bits using the registered carry; the result equals the full WIDTH-bit sum modulo 2^WIDTH.
REQ-017 C SHALL be the carry out of bit WIDTH-1 of the raw sum.
REQ-018 Unsigned V SHALL be C for add and ~C for subtract.
REQ-019 Signed V SHALL be 1 iff operand-B-effective and A share a sign bit differing from raw S[WIDTH-1].
REQ-020 N SHALL be (S_raw[WIDTH-1] ^ V) when Sign=1; ~C when Sign=0 and Sub=1; 0 when Sign=0 and Sub=0.
REQ-021 Z SHALL be 1 iff the final output S (after any saturation) is all zeros.
REQ-022 Each stage SHALL load when empty or when its downstream stage empties in the same cycle; in_ready = !v1 | !v2 | out_ready.
REQ-023 While out_valid=1 and out_ready=0, S, flags and out_valid SHALL hold stable.
REQ-024 Simultaneous accept at input and drain at output SHALL sustain one beat per cycle with no bubble.
REQ-025 No beat SHALL be dropped or duplicated; ordering SHALL be preserved.
REQ-026 in_valid with in_ready=0 SHALL NOT alter any state.

Reset
REQ-027 reset low SHALL immediately clear both stage valid bits; out_valid=0, S=0, Z=1, V=0, N=0, C=0.
REQ-028 reset asserted mid-operation SHALL discard all in-flight beats; in_ready=1 from the first cycle after reset release.
REQ-029 Datapath registers other than outputs need not be reset.

Configuration
REQ-030 Macro ADD_SUB_PIPE_SAT_EN, when defined, SHALL saturate S whenever V=1: unsigned add -> all ones; unsigned sub -> 0; signed -> 2^(WIDTH-1)-1 if A[WIDTH-1]=0 else 2^(WIDTH-1).
REQ-031 With ADD_SUB_PIPE_SAT_EN defined, V, N and C SHALL still reflect the raw (unsaturated) operation; Z follows saturated S.
REQ-032 Without ADD_SUB_PIPE_SAT_EN, S SHALL wrap modulo 2^WIDTH; port list identical in both builds.

Verification (WIDTH=32)
REQ-033 A=0x0000FFFF,B=1,Sub=0,Sign=0, out_ready=1 -> 2 cycles later S=0x00010000,Z=0,V=0,C=0 (carry crosses LO_W boundary).
REQ-034 A=0x7FFFFFFF,B=1,Sub=0,Sign=1 -> V=1,N=0; S=0x80000000 without macro, 0x7FFFFFFF with ADD_SUB_PIPE_SAT_EN.
REQ-035 A=3,B=5,Sub=1,Sign=0 -> S=0xFFFFFFFE,V=1,N=1,C=0; with macro S=0,Z=1.
REQ-036 Back-to-back 8 beats, out_ready held 0 for cycles 3-6 -> in_ready drops after 2 beats buffered, outputs hold stable, all 8 results emerge in order, no loss.
REQ-037 Continuous input and out_ready=1 for 16 cycles -> 1 result per cycle after 2-cycle fill.
REQ-038 reset pulsed low with 2 beats in flight -> out_valid=0 immediately, neither beat ever emerges, next accepted beat returns correct result.

Source files
------------

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: two-stage pipelined adder/subtractor with valid/ready handshake.
// Stage 1 adds the low LO_W bits and registers the carry plus the upper operand
// bits; stage 2 finishes the upper bits and derives the Z/V/N/C flags.
// Optional build macro: ADD_SUB_PIPE_SAT_EN saturates S on overflow.
module add_sub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LO_W  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Z,
  output logic             V,
  output logic             N,
  output logic             C
);

  localparam int unsigned HI_W = WIDTH - LO_W;

  // Stage 1 state
  logic            v1_q;
  logic [LO_W-1:0] lo_q;
  logic            cy_q;
  logic [HI_W-1:0] a_hi_q;
  logic [HI_W-1:0] b_hi_q;
  logic            sub_q;
  logic            sign_q;

  // Handshake: a stage loads when empty or when its successor drains this cycle
  logic ld1;
  logic ld2;

  assign in_ready = !v1_q || !out_valid || out_ready;
  assign ld1      = in_valid && in_ready;
  assign ld2      = v1_q && (!out_valid || out_ready);

  // Stage 1 combinational low-half sum with effective (possibly inverted) B
  logic [WIDTH-1:0] b_eff_c;
  logic [LO_W:0]    lo_sum_c;

  assign b_eff_c  = Sub ? ~B : B;
  assign lo_sum_c = {1'b0, A[LO_W-1:0]} + {1'b0, b_eff_c[LO_W-1:0]} + (LO_W+1)'(Sub);

  // Stage 2 combinational upper-half sum, flags and optional saturation
  logic [HI_W:0]    hi_sum_c;
  logic [WIDTH-1:0] raw_c;
  logic             c_c;
  logic             v_c;
  logic             n_c;
  logic             a_msb_c;
  logic             b_msb_c;
  logic             s_msb_c;
  logic [WIDTH-1:0] s_fin_c;

  assign hi_sum_c = {1'b0, a_hi_q} + {1'b0, b_hi_q} + (HI_W+1)'(cy_q);
  assign raw_c    = {hi_sum_c[HI_W-1:0], lo_q};
  assign c_c      = hi_sum_c[HI_W];
  assign a_msb_c  = a_hi_q[HI_W-1];
  assign b_msb_c  = b_hi_q[HI_W-1];
  assign s_msb_c  = raw_c[WIDTH-1];

  // Overflow and less-than/negative from the raw (unsaturated) result
  always_comb begin
    v_c = 1'b0;
    n_c = 1'b0;
    if (sign_q) begin
      v_c = (a_msb_c == b_msb_c) && (s_msb_c != a_msb_c);
      n_c = s_msb_c ^ v_c;
    end else begin
      v_c = sub_q ? ~c_c : c_c;
      n_c = sub_q ? ~c_c : 1'b0;
    end
  end

  // Final result: clamp on overflow when saturation is built in, else wrap
  always_comb begin
    s_fin_c = raw_c;
`ifdef ADD_SUB_PIPE_SAT_EN
    if (v_c) begin
      if (sign_q) begin
        s_fin_c = a_msb_c ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        s_fin_c = sub_q ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
      end
    end
`endif
  end

  // Stage valid bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (ld1)      v1_q <= 1'b1;
      else if (ld2) v1_q <= 1'b0;
      if (ld2)            out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  // Stage 1 datapath; qualified by v1_q so it needs no reset
  always_ff @(posedge clk) begin
    if (ld1) begin
      lo_q   <= lo_sum_c[LO_W-1:0];
      cy_q   <= lo_sum_c[LO_W];
      a_hi_q <= A[WIDTH-1:LO_W];
      b_hi_q <= b_eff_c[WIDTH-1:LO_W];
      sub_q  <= Sub;
      sign_q <= Sign;
    end
  end

  // Stage 2 output registers; hold while the consumer stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      S <= '0;
      Z <= 1'b1;
      V <= 1'b0;
      N <= 1'b0;
      C <= 1'b0;
    end else if (ld2) begin
      S <= s_fin_c;
      Z <= (s_fin_c == '0);
      V <= v_c;
      N <= n_c;
      C <= c_c;
    end
  end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed testbench for add_sub_pipe (WIDTH=32), both saturation builds.
module tb_add_sub_pipe;

`ifdef ADD_SUB_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        z;
  logic        v;
  logic        n;
  logic        c;

  int total;
  int bad;

  add_sub_pipe #(.WIDTH(32), .LO_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Sub(sub), .Sign(sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(s), .Z(z), .V(v), .N(n), .C(c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One isolated beat with out_ready=1; checks 2-cycle latency and all outputs
  task automatic send_one(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic isub, input logic isign, input logic [31:0] es,
                          input logic ez, input logic ev, input logic en, input logic ec);
    @(negedge clk);
    a = ia; b = ib; sub = isub; sign = isign; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".ov"}, 32'(out_valid), 32'd1);
    chk({tag, ".S"},  s, es);
    chk({tag, ".Z"},  32'(z), 32'(ez));
    chk({tag, ".V"},  32'(v), 32'(ev));
    chk({tag, ".N"},  32'(n), 32'(en));
    chk({tag, ".C"},  32'(c), 32'(ec));
  endtask

  // Stream nb beats; out_ready low in cycles [st_lo, st_hi]; checks order and hold
  task automatic run_stream(input string tag, input int nb, input int st_lo, input int st_hi,
                            input int ncyc, input bit chk_ov, input logic [31:0] base);
    logic [31:0] exp_q[$];
    logic [31:0] held_s;
    bit          hold;
    int          sent;
    int          rcv;
    sent = 0; rcv = 0; hold = 1'b0; held_s = '0;
    for (int cy = 0; cy < ncyc; cy++) begin
      @(negedge clk);
      out_ready = !(cy >= st_lo && cy <= st_hi);
      in_valid  = (sent < nb);
      a   = base + 32'h0001_0000 * 32'(sent) + 32'h0000_FFF8 + 32'(sent);
      b   = 32'h10 + 32'd3 * 32'(sent);
      sub = sent[0];
      sign = 1'b0;
      #1;
      if (hold) begin
        chk({tag, ".hold_ov"}, 32'(out_valid), 32'd1);
        chk({tag, ".hold_S"}, s, held_s);
      end
      if (cy >= st_lo && cy <= st_hi) chk({tag, ".stall_rdy"}, 32'(in_ready), 32'd0);
      if (chk_ov) begin
        chk({tag, ".ov"}, 32'(out_valid), 32'((cy >= 2 && cy < nb + 2) ? 1 : 0));
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
      end
      if (out_valid && out_ready) begin
        chk({tag, ".extra"}, 32'(rcv < nb), 32'd1);
        if (rcv < nb) chk($sformatf("%s.S%0d", tag, rcv), s, exp_q[rcv]);
        rcv++;
      end
      hold   = out_valid && !out_ready;
      held_s = s;
      if (in_valid && in_ready) begin
        exp_q.push_back(sub ? a - b : a + b);
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, ".count"}, 32'(rcv), 32'(nb));
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; sign = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.S",  s, 32'd0);
    chk("rst.Z",  32'(z), 32'd1);
    chk("rst.VNC", {29'd0, v, n, c}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed single beats
    send_one("carry_lo", 32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    send_one("s_addov", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1,
             SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    send_one("u_subov", 32'd3, 32'd5, 1'b1, 1'b0,
             SAT ? 32'h0 : 32'hFFFF_FFFE, SAT, 1'b1, 1'b1, 1'b0);
    send_one("u_subeq", 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    send_one("s_lt", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    send_one("s_subov", 32'h8000_0000, 32'd1, 1'b1, 1'b1,
             SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b1);
    send_one("u_addov", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0,
             SAT ? 32'hFFFF_FFFF : 32'h1, 1'b0, 1'b1, 1'b0, 1'b1);
    send_one("s_addneg", 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    send_one("u_subge", 32'h10, 32'd3, 1'b1, 1'b0, 32'hD, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure: 8 beats, consumer stalls cycles 3..6
    run_stream("stall", 8, 3, 6, 24, 1'b0, 32'h0);
    // Full-rate streaming: 16 beats
    run_stream("stream", 16, 1000, 1000, 20, 1'b1, 32'h4000_0000);

    // Reset with two beats in flight
    @(negedge clk);
    a = 32'hAAAA_0000; b = 32'h1111; sub = 1'b0; sign = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    a = 32'hBBBB_0000; b = 32'h2222;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid.ov_pre", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid.ov", 32'(out_valid), 32'd0);
    chk("mid.S", s, 32'd0);
    chk("mid.Z", 32'(z), 32'd1);
    chk("mid.VNC", {29'd0, v, n, c}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post.ov", 32'(out_valid), 32'd0);
      chk("post.rdy", 32'(in_ready), 32'd1);
    end
    send_one("after_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000,
             1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
